// File: rtl/craps_pkg.sv
// Shared types and constants for the craps game controller.
package craps_pkg;

   typedef enum logic [1:0] {COMEOUT, POINT, WIN, LOSE} state_t;

   localparam int DIE_W = 3;
   localparam int SUM_W = 4;
   localparam int CNT_W = 8;

   localparam logic [SUM_W-1:0] SUM_SEVEN     = 4'd7;
   localparam logic [SUM_W-1:0] SUM_ELEVEN    = 4'd11;
   localparam logic [SUM_W-1:0] SUM_SNAKE     = 4'd2;
   localparam logic [SUM_W-1:0] SUM_ACE_DEUCE = 4'd3;
   localparam logic [SUM_W-1:0] SUM_BOXCARS   = 4'd12;

   // A die face is legal only in 1..6; the 3-bit encodings 0 and 7 are rejected.
   function automatic logic die_ok(input logic [DIE_W-1:0] d);
      return (d != '0) && (d != '1);
   endfunction

endpackage

// File: rtl/craps_game_if.sv
// Roll/dice inputs and game status outputs of the craps controller.
interface craps_game_if;
   import craps_pkg::*;

   logic             roll;
   logic [DIE_W-1:0] dice1;
   logic [DIE_W-1:0] dice2;
   logic             new_game;
   logic [SUM_W-1:0] sum;
   logic [SUM_W-1:0] point;
   logic             win;
   logic             lose;
   logic             point_on;
   logic             roll_done;
   logic             roll_err;
   logic [CNT_W-1:0] roll_count;

   modport master (
      output roll, dice1, dice2, new_game,
      input  sum, point, win, lose, point_on, roll_done, roll_err, roll_count
   );

   modport slave (
      input  roll, dice1, dice2, new_game,
      output sum, point, win, lose, point_on, roll_done, roll_err, roll_count
   );

endinterface

// File: rtl/craps_game_sync_rise_detect.sv
// Synchronizer chain plus rising-edge detect; all flops reset high so a
// level already high at reset release never looks like an edge.
module sync_rise_detect #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   // [STAGES-1] is the synchronized level, [STAGES] its one-cycle history.
   logic [STAGES:0] vld_pipe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_pipe <= '1;
      else     vld_pipe <= {vld_pipe[STAGES-1:0], din};
   end

   assign rise = vld_pipe[STAGES-1] & ~vld_pipe[STAGES];

endmodule

// File: rtl/craps_game.sv
// Craps rules controller: samples the dice on each roll event and tracks
// come-out / point / win / lose with registered status outputs.
module craps_game
   import craps_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   craps_game_if.slave  bus
);

   state_t           state, state_nx;
   logic [SUM_W-1:0] sum_q, sum_nx;
   logic [SUM_W-1:0] point_q, point_nx;
   logic [CNT_W-1:0] cnt_q, cnt_nx;
   logic             done_q, done_nx;
   logic             err_q, err_nx;
   logic             win_q, lose_q, pon_q;
   logic             roll_ev;
   logic             dice_ok;
   logic [SUM_W-1:0] roll_sum;

   sync_rise_detect #(.STAGES(SYNC_STAGES)) u_roll_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (bus.roll),
      .rise (roll_ev)
   );

   assign dice_ok  = die_ok(bus.dice1) && die_ok(bus.dice2);
   assign roll_sum = {1'b0, bus.dice1} + {1'b0, bus.dice2};

   always_comb begin
      state_nx = state;
      sum_nx   = sum_q;
      point_nx = point_q;
      cnt_nx   = cnt_q;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      // new_game wins over any roll event landing in the same cycle
      if (bus.new_game) begin
         state_nx = COMEOUT;
         sum_nx   = '0;
         point_nx = '0;
         cnt_nx   = '0;
      end else if (roll_ev && (state == COMEOUT || state == POINT)) begin
         if (!dice_ok) begin
            err_nx = 1'b1;
         end else begin
            done_nx = 1'b1;
            sum_nx  = roll_sum;
            if (cnt_q != '1) cnt_nx = cnt_q + 1'b1;
            unique case (state)
               COMEOUT: begin
                  if (roll_sum == SUM_SEVEN || roll_sum == SUM_ELEVEN)
                     state_nx = WIN;
                  else if (roll_sum == SUM_SNAKE || roll_sum == SUM_ACE_DEUCE ||
                           roll_sum == SUM_BOXCARS)
                     state_nx = LOSE;
                  else begin
                     state_nx = POINT;
                     point_nx = roll_sum;
                  end
               end
               POINT: begin
                  if (roll_sum == point_q)        state_nx = WIN;
                  else if (roll_sum == SUM_SEVEN) state_nx = LOSE;
               end
               default: ;
            endcase
         end
      end
   end

   // Status levels are registered from the next state so outputs carry no
   // decode logic after the flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= COMEOUT;
         sum_q   <= '0;
         point_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         win_q   <= 1'b0;
         lose_q  <= 1'b0;
         pon_q   <= 1'b0;
      end else begin
         state   <= state_nx;
         sum_q   <= sum_nx;
         point_q <= point_nx;
         cnt_q   <= cnt_nx;
         done_q  <= done_nx;
         err_q   <= err_nx;
         win_q   <= (state_nx == WIN);
         lose_q  <= (state_nx == LOSE);
         pon_q   <= (state_nx == POINT);
      end
   end

   assign bus.sum        = sum_q;
   assign bus.point      = point_q;
   assign bus.win        = win_q;
   assign bus.lose       = lose_q;
   assign bus.point_on   = pon_q;
   assign bus.roll_done  = done_q;
   assign bus.roll_err   = err_q;
   assign bus.roll_count = cnt_q;

endmodule
